// File: rtl/piradip_cdc_pkg.sv
// Shared helpers for the piradip CDC stream stages.
// Sizing function plus an elaboration-time depth check macro.
package piradip_cdc_pkg;

  // Address width for a table of n entries, never below one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`ifndef PIRADIP_CHECK_POW2
`define PIRADIP_CHECK_POW2(blk, val) \
  if (((val) < 2) || ((((val) - 1) & (val)) != 0)) begin : blk \
    $error("depth must be a power of two >= 2"); \
  end
`endif

// File: rtl/piradip_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers.
// Storage is never reset; only the pointers are.
module piradip_sync_fifo
  import piradip_cdc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = clog2_min1(DEPTH);
  localparam int PW = AW + 1;

  `PIRADIP_CHECK_POW2(g_depth_chk, DEPTH)

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;

  // A pop frees a slot in the same cycle, so push may proceed when full.
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;

  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Storage write, no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // Pointer advance; reset discards every buffered word.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/piradip_cdc_update_stream.sv
// Turns the CDC data/update pair into a valid/ready stream.
// Overflowing words are dropped, counted and flagged.
module piradip_cdc_update_stream
  import piradip_cdc_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 4,
  parameter int EDGE_DETECT = 1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_update,
  output logic [WIDTH-1:0]       m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [CNT_WIDTH-1:0]   drop_count,
  input  logic                   clr_stats
);

  logic in_update_q;
  logic push;
  logic pop;
  logic full;
  logic empty;
  logic drop;

  // Update history for rising-edge capture.
  always_ff @(posedge clk) begin
    if (rst) in_update_q <= 1'b0;
    else     in_update_q <= in_update;
  end

  if (EDGE_DETECT != 0) begin : g_edge
    assign push = in_update & ~in_update_q;
  end else begin : g_level
    assign push = in_update;
  end

  assign m_valid = ~empty;
  assign pop     = m_valid & m_ready;
  assign drop    = push & full & ~pop;

  piradip_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (in_data),
    .pop   (pop),
    .rdata (m_data),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // Drop statistics; a same-cycle drop wins over the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clr_stats) begin
      overflow   <= drop;
      drop_count <= drop ? CNT_WIDTH'(1) : '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != '1) drop_count <= drop_count + 1'b1;
    end
  end

endmodule
